// File: rtl/ball_renderer.sv
// Overlays a square ball on the timing generator's pixel stream. The ball position is
// sampled once per frame into shadow registers, and the colour comes out of a two-stage pipeline.
module ball_renderer #(
  parameter int          BALL_SIZE  = 16,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [11:0] BALL_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR   = 12'h00F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pixel_x,
  input  logic [15:0] pixel_y,
  input  logic        video_active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_start,
  input  logic [15:0] x_pos,
  input  logic [15:0] y_pos,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        pos_latched,
  output logic        clipped
);

  localparam logic [15:0] X_MAX    = 16'(H_ACTIVE - BALL_SIZE);
  localparam logic [15:0] Y_MAX    = 16'(V_ACTIVE - BALL_SIZE);
  localparam logic [16:0] SIZE_EXT = 17'(BALL_SIZE);

  logic [15:0] sx, sy;
  logic        x_clamp, y_clamp;
  logic [16:0] x_end, y_end;
  logic        hit;
  logic        s1_hit, s1_active, s1_hsync, s1_vsync;

  assign x_clamp = (x_pos > X_MAX);
  assign y_clamp = (y_pos > Y_MAX);

  // Right/bottom edges are 17 bits wide so a ball near 16'hFFFF cannot wrap around
  assign x_end = {1'b0, sx} + SIZE_EXT;
  assign y_end = {1'b0, sy} + SIZE_EXT;
  assign hit   = (pixel_x >= sx) && ({1'b0, pixel_x} < x_end) &&
                 (pixel_y >= sy) && ({1'b0, pixel_y} < y_end);

  // Shadow position only moves at frame_start, so the ball never tears mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx          <= '0;
      sy          <= '0;
      clipped     <= 1'b0;
      pos_latched <= 1'b0;
    end else begin
      pos_latched <= frame_start;
      if (frame_start) begin
        sx      <= x_clamp ? X_MAX : x_pos;
        sy      <= y_clamp ? Y_MAX : y_pos;
        clipped <= x_clamp || y_clamp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit    <= 1'b0;
      s1_active <= 1'b0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
    end else begin
      s1_hit    <= hit;
      s1_active <= video_active;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      if (!s1_active)
        rgb <= 12'h000;
      else if (s1_hit)
        rgb <= BALL_COLOR;
      else
        rgb <= BG_COLOR;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer: directed cases with literal expectations plus
// randomized pixels compared every cycle against a per-frame position model.
module tb_ball_renderer;

  localparam int BALL = 16;
  localparam int XMAX = 640 - BALL;
  localparam int YMAX = 480 - BALL;

  logic        clk;
  logic        rst;
  logic [15:0] pixel_x, pixel_y;
  logic        video_active, hsync_in, vsync_in, frame_start;
  logic [15:0] x_pos, y_pos;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, pos_latched, clipped;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];
  int   m_sx, m_sy;
  bit   m_clipped;
  bit   exp_pl;
  int   checks;
  int   failures;

  ball_renderer dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_active (video_active),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .frame_start  (frame_start),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .pos_latched  (pos_latched),
    .clipped      (clipped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Compares every output against the model once per cycle
  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("model_queue_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("rgb", rgb, e.rgb);
    check("hsync_out", hsync_out, e.hs);
    check("vsync_out", vsync_out, e.vs);
    check("pos_latched", pos_latched, exp_pl);
    check("clipped", clipped, m_clipped);
  endtask

  task automatic applyStimulus(input int px, input int py, input bit act, input bit hs,
                               input bit vs, input bit fs, input int xp, input int yp);
    exp_t e;
    bit   in_ball;
    pixel_x      = px[15:0];
    pixel_y      = py[15:0];
    video_active = act;
    hsync_in     = hs;
    vsync_in     = vs;
    frame_start  = fs;
    x_pos        = xp[15:0];
    y_pos        = yp[15:0];
    in_ball = (px >= m_sx) && (px < m_sx + BALL) && (py >= m_sy) && (py < m_sy + BALL);
    e.rgb = !act ? 12'h000 : (in_ball ? 12'hF00 : 12'h00F);
    e.hs  = hs;
    e.vs  = vs;
    exp_q.push_back(e);
    // The pixel above was judged against the old position; the new one applies from next cycle
    if (fs) begin
      m_sx      = (xp > XMAX) ? XMAX : xp;
      m_sy      = (yp > YMAX) ? YMAX : yp;
      m_clipped = (xp > XMAX) || (yp > YMAX);
    end
    @(posedge clk);
    #1;
    exp_pl = fs;
    checkOutput();
  endtask

  task automatic idle(input int xp, input int yp);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, xp, yp);
  endtask

  // Sends one pixel through the pipeline and pins its colour to a literal
  task automatic pixelLiteral(input string name, input int px, input int py, input bit act,
                              input int xp, input int yp, input logic [11:0] lit);
    applyStimulus(px, py, act, 1'b1, 1'b1, 1'b0, xp, yp);
    idle(xp, yp);
    check(name, rgb, lit);
  endtask

  task automatic resetPulse();
    exp_t e;
    rst = 1'b1;
    #1;
    check("rst_rgb", rgb, 12'h000);
    check("rst_hsync", hsync_out, 1'b1);
    check("rst_vsync", vsync_out, 1'b1);
    check("rst_pos_latched", pos_latched, 1'b0);
    check("rst_clipped", clipped, 1'b0);
    m_sx = 0;
    m_sy = 0;
    m_clipped = 1'b0;
    exp_pl = 1'b0;
    exp_q.delete();
    e.rgb = 12'h000;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pixel_x = '0; pixel_y = '0; video_active = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0;
    x_pos = '0; y_pos = '0;
    resetPulse();

    pixelLiteral("origin_hit", 0, 0, 1'b1, 100, 50, 12'hF00);
    pixelLiteral("origin_edge", 16, 0, 1'b1, 100, 50, 12'h00F);

    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 100, 50);
    check("lit_pos_latched", pos_latched, 1'b1);
    idle(100, 50);
    check("lit_pos_latched_drop", pos_latched, 1'b0);
    check("lit_clipped_lo", clipped, 1'b0);
    pixelLiteral("ball_corner", 100, 50, 1'b1, 100, 50, 12'hF00);
    pixelLiteral("left_of_ball", 99, 50, 1'b1, 100, 50, 12'h00F);
    pixelLiteral("right_of_ball", 116, 50, 1'b1, 100, 50, 12'h00F);
    pixelLiteral("below_ball", 100, 66, 1'b1, 100, 50, 12'h00F);
    pixelLiteral("ball_far_corner", 115, 65, 1'b1, 100, 50, 12'hF00);

    pixelLiteral("no_tear_old", 100, 50, 1'b1, 300, 50, 12'hF00);
    pixelLiteral("no_tear_new", 300, 50, 1'b1, 300, 50, 12'h00F);

    pixelLiteral("inactive_hit", 100, 50, 1'b0, 300, 50, 12'h000);
    applyStimulus(5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 300, 50);
    check("lit_hsync_1cyc", hsync_out, 1'b1);
    idle(300, 50);
    check("lit_hsync_2cyc", hsync_out, 1'b0);
    check("lit_vsync_2cyc", vsync_out, 1'b0);
    idle(300, 50);
    check("lit_hsync_back", hsync_out, 1'b1);

    applyStimulus(100, 50, 1'b1, 1'b1, 1'b1, 1'b1, 200, 50);
    applyStimulus(200, 50, 1'b1, 1'b1, 1'b1, 1'b0, 200, 50);
    check("lit_fs_old_pos", rgb, 12'hF00);
    idle(200, 50);
    check("lit_fs_new_pos", rgb, 12'hF00);

    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 700, 470);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 700, 470);
    check("lit_back_to_back_pl", pos_latched, 1'b1);
    check("lit_clipped_hi", clipped, 1'b1);
    pixelLiteral("clamp_corner", 639, 479, 1'b1, 700, 470, 12'hF00);
    pixelLiteral("clamp_left", 623, 479, 1'b1, 700, 470, 12'h00F);
    pixelLiteral("clamp_topleft", 624, 464, 1'b1, 700, 470, 12'hF00);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 10, 10);
    check("lit_clipped_clear", clipped, 1'b0);

    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 100, 50);
    pixelLiteral("pre_reset_ball", 100, 50, 1'b1, 100, 50, 12'hF00);
    applyStimulus(100, 50, 1'b1, 1'b0, 1'b0, 1'b0, 100, 50);
    #1;
    resetPulse();
    pixelLiteral("post_reset_origin", 0, 0, 1'b1, 100, 50, 12'hF00);
    pixelLiteral("post_reset_old_ball", 100, 50, 1'b1, 100, 50, 12'h00F);

    for (int n = 0; n < 3000; n++) begin
      int px, py;
      if ($urandom_range(0, 1) == 1) begin
        px = m_sx + int'($urandom_range(0, 40)) - 20;
        py = m_sy + int'($urandom_range(0, 40)) - 20;
      end else begin
        px = int'($urandom_range(0, 700));
        py = int'($urandom_range(0, 520));
      end
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      applyStimulus(px, py, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 800)), int'($urandom_range(0, 600)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_renderer.md
BALL_RENDERER -- requirements
Module: ball_renderer

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 16, ball edge length in pixels.
REQ-002 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter BALL_COLOR, default 12'hF00, ball pixel colour.
REQ-005 SHALL have parameter BG_COLOR, default 12'h00F, background colour inside the active area.
REQ-006 SHALL have port clk  input  1  pixel clock.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port pixel_x  input  16  current pixel column from the timing generator.
REQ-009 SHALL have port pixel_y  input  16  current pixel row from the timing generator.
REQ-010 SHALL have port video_active  input  1  high when (pixel_x, pixel_y) is in the visible area.
REQ-011 SHALL have port hsync_in  input  1  horizontal sync from the timing generator.
REQ-012 SHALL have port vsync_in  input  1  vertical sync from the timing generator.
REQ-013 SHALL have port frame_start  input  1  one-cycle pulse at the start of vertical blanking.
REQ-014 SHALL have port x_pos  input  16  requested ball left edge from the movement logic.
REQ-015 SHALL have port y_pos  input  16  requested ball top edge from the movement logic.
REQ-016 SHALL have port rgb  output  12  pixel colour, {R[3:0],G[3:0],B[3:0]}.
REQ-017 SHALL have port hsync_out  output  1  hsync_in delayed to align with rgb.
REQ-018 SHALL have port vsync_out  output  1  vsync_in delayed to align with rgb.
REQ-019 SHALL have port pos_latched  output  1  one-cycle pulse when the shadow position updates.
REQ-020 SHALL have port clipped  output  1  high while the latched position was clamped.

Function
REQ-021 SHALL hold shadow registers sx, sy (16 bit); x_pos/y_pos SHALL affect drawing only through them (no mid-frame tearing).
REQ-022 On a frame_start cycle, sx SHALL load min(x_pos, H_ACTIVE-BALL_SIZE) and sy SHALL load min(y_pos, V_ACTIVE-BALL_SIZE), unsigned compare.
REQ-023 On the same edge, clipped SHALL load 1 if either value was clamped, else 0; it SHALL hold until the next frame_start.
REQ-024 pos_latched SHALL be high exactly the cycle after each frame_start cycle; back-to-back frame_start cycles SHALL each produce a pulse.
REQ-025 A pixel presented in the frame_start cycle SHALL be compared against the old sx/sy.
REQ-026 Hit SHALL be sx <= pixel_x < sx+BALL_SIZE and sy <= pixel_y < sy+BALL_SIZE; sums SHALL be 17-bit (no wrap).
REQ-027 Stage 1 SHALL register hit, video_active, hsync_in and vsync_in.
REQ-028 Stage 2 SHALL register rgb = BALL_COLOR if active and hit, BG_COLOR if active and not hit, 12'h000 if not active; it SHALL also register the stage-1 syncs.
REQ-029 Latency from pixel inputs to rgb/hsync_out/vsync_out SHALL be exactly 2 cycles, with no bubbles and throughput 1 pixel/cycle.
REQ-030 rgb SHALL be 12'h000 whenever the aligned video_active is low, regardless of hit.
REQ-031 Pipeline stages SHALL have no enable and shall advance every cycle.

Reset
REQ-032 rst SHALL asynchronously force sx=0, sy=0, clipped=0, pos_latched=0, rgb=12'h000, hsync_out=1, vsync_out=1 and all stage-1 flops to their inactive equivalents (active=0, hit=0, syncs=1).
REQ-033 After rst deasserts, the block SHALL draw the ball at (0,0) until the first frame_start.
REQ-034 rst asserted mid-line SHALL take effect immediately; the first valid rgb SHALL appear 2 cycles after the first post-reset clock edge.

Verification
REQ-035 Reset, then frame_start with x_pos=100, y_pos=50 -> pos_latched pulse; pixel (100,50) active gives rgb=12'hF00 two cycles later; (99,50), (116,50) and (100,66) give 12'h00F.
REQ-036 x_pos=700, y_pos=470 at frame_start -> sx=624, sy=464, clipped=1; pixel (639,479) -> 12'hF00.
REQ-037 Change x_pos from 100 to 300 mid-frame without frame_start -> pixel (100,50) is still 12'hF00 and (300,50) is 12'h00F until the next frame_start.
REQ-038 Pixel (100,50) hit with video_active=0 -> rgb=12'h000; hsync_in/vsync_in toggles reappear on hsync_out/vsync_out exactly 2 cycles later.
REQ-039 frame_start in the same cycle as pixel (100,50) while the pending x_pos=200 -> that pixel is still drawn from the old sx=100 (12'hF00), and the next cycle uses sx=200.
REQ-040 Assert rst for 1 cycle mid-frame after a ball at (100,50) -> outputs go to reset values asynchronously, and (0,0) is drawn as 12'hF00 afterwards.
